// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debounce / press-pulse front end.
package debounce_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned DEFAULT_CNT_MAX = 4;
  localparam int unsigned DEFAULT_CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser; synchronous active-low reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/debounce_pulse_gen.sv
// Synchronises and debounces a raw button level, emitting one registered
// single-cycle pulse per accepted press plus the debounced level.
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_in,
  output logic               pulse_out,
  output logic               level_out,
  output logic [STATE_W-1:0] p_state,
  output logic [CNT_W-1:0]   cnt_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             btn_s;
  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             pulse_n;
  logic             level_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // State, stability counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      pulse_out <= 1'b0;
      level_out <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      pulse_out <= pulse_n;
      level_out <= level_n;
    end
  end

  // Next state, counter and output decode.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pulse_n = 1'b0;

    case (state_q)
      LOW: begin
        if (btn_s) begin
          state_n = RISE_CHK;
          cnt_n   = '0;
        end
      end
      RISE_CHK: begin
        if (!btn_s) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = HIGH;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_n = FALL_CHK;
          cnt_n   = '0;
        end
      end
      FALL_CHK: begin
        if (btn_s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      // Corrupted state recovers to idle.
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase

    level_n = (state_n == HIGH) || (state_n == FALL_CHK);
  end

  assign p_state = state_q;
  assign cnt_dbg = cnt_q;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed bench for debounce_pulse_gen: pulse timing via an expected-cycle
// scoreboard, state/level checks inline, and a downstream toggle model.
module tb_debounce_pulse_gen;

  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_in;
  logic             pulse_out;
  logic             level_out;
  logic [1:0]       p_state;
  logic [CNT_W-1:0] cnt_dbg;
  logic             dout;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  int exp_q[$];

  int exp_st [8] = '{0, 0, 1, 1, 1, 1, 2, 2};
  int exp_pl [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int exp_lv [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

  debounce_pulse_gen #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .level_out (level_out),
    .p_state   (p_state),
    .cnt_dbg   (cnt_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream Moore toggle stage driven by pulse_out.
  always @(posedge clk) begin
    if (!rst) dout <= 1'b0;
    else if (pulse_out) dout <= ~dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  // Every observed pulse cycle must match the next scheduled expectation.
  always @(negedge clk) begin
    int e;
    if (pulse_out === 1'b1) begin
      pulse_cnt++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      chk("pulse_time", 32'(cyc), 32'(e));
    end
  end

  initial begin
    int t0;
    int base;
    logic seen;
    logic [31:0] pat;

    // Reset
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("rst_pulse", 32'(pulse_out), 32'd0);
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_state", 32'(p_state), 32'd0);
    chk("rst_cnt", 32'(cnt_dbg), 32'd0);

    // Clean press
    rst = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + 7);
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      chk("clean_state", 32'(p_state), 32'(exp_st[i]));
      chk("clean_pulse", 32'(pulse_out), 32'(exp_pl[i]));
      chk("clean_level", 32'(level_out), 32'(exp_lv[i]));
    end
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("clean_rel_state", 32'(p_state), 32'd0);
    chk("clean_rel_level", 32'(level_out), 32'd0);

    // Bounce rejection: 1,0,1,1,0 then low
    pat = 32'b01101;
    seen = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step((i < 5) ? pat[i] : 1'b0);
      seen = seen | level_out;
      if (i == 5) begin
        chk("bounce_state_mid", 32'(p_state), 32'd1);
        chk("bounce_cnt_mid", 32'(cnt_dbg), 32'd1);
      end
    end
    chk("bounce_level_seen", 32'(seen), 32'd0);
    chk("bounce_state_end", 32'(p_state), 32'd0);

    // Bouncy press then stable: 1,0,1 then ten 1s
    t0 = cyc;
    exp_q.push_back(t0 + 9);
    for (int i = 0; i < 13; i++) step((i == 1) ? 1'b0 : 1'b1);
    chk("bouncy_state", 32'(p_state), 32'd2);
    chk("bouncy_level", 32'(level_out), 32'd1);

    // Hold 20, then release bounce 0,1,0 and steady low
    t0 = cyc;
    for (int i = 1; i <= 35; i++) begin
      step((i <= 20 || i == 22) ? 1'b1 : 1'b0);
      if (cyc == t0 + 25) begin
        chk("rel_fallchk", 32'(p_state), 32'd3);
        chk("rel_cnt0", 32'(cnt_dbg), 32'd0);
      end
      if (cyc == t0 + 28) chk("rel_level_hold", 32'(level_out), 32'd1);
      if (cyc == t0 + 29) chk("rel_level_fall", 32'(level_out), 32'd0);
    end
    chk("rel_state_end", 32'(p_state), 32'd0);

    // Reset mid-debounce with button held through release
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("mid_state", 32'(p_state), 32'd1);
    chk("mid_cnt", 32'(cnt_dbg), 32'd2);
    rst = 1'b0;
    step(1'b1);
    chk("mid_rst_pulse", 32'(pulse_out), 32'd0);
    chk("mid_rst_level", 32'(level_out), 32'd0);
    chk("mid_rst_state", 32'(p_state), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_dbg), 32'd0);
    rst = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + 7);
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("mid_after_state", 32'(p_state), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("mid_rel_state", 32'(p_state), 32'd0);

    // Back-to-back presses into the toggle stage
    rst = 1'b0;
    step(1'b0);
    chk("tog_rst_dout", 32'(dout), 32'd0);
    rst = 1'b1;
    base = pulse_cnt;
    for (int p = 0; p < 3; p++) begin
      t0 = cyc;
      exp_q.push_back(t0 + 7);
      for (int i = 0; i < 8; i++) step(1'b1);
      chk("tog_dout", 32'(dout), (p == 1) ? 32'd0 : 32'd1);
      for (int i = 0; i < 10; i++) step(1'b0);
    end
    chk("tog_pulse_total", 32'(pulse_cnt - base), 32'd3);

    step(1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_gen.md
Name: debounce_pulse_gen

Overview:
- Front-end conditioning stage that sits directly upstream of the Moore toggle FSM and drives its din input.
- Takes a raw, asynchronous, bouncy push-button/switch level and synchronises it into clk.
- Debounces it with a saturating stability counter.
- Emits exactly one single-cycle pulse per validated press, so the downstream FSM sees one din=1 cycle per press.
- Also exports the debounced level and present state for debugging.

Parameters:
- CNT_MAX, 4, number of consecutive stable synchronised samples required to accept an edge; legal range 2..65535.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- btn_in  input  1  raw asynchronous button level, may bounce.
- pulse_out  output  1  registered one-cycle press pulse, feeds downstream din.
- level_out  output  1  registered debounced level.
- p_state  output  2  present FSM state (debug).
- cnt_dbg  output  CNT_W  present stability count (debug).

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-low. While rst=0 at a rising edge, every register clears:
  - sync_q1=0, sync_q2=0, p_state=LOW, cnt=0, pulse_out=0, level_out=0.
  - There is no asynchronous path.
- Synchroniser: btn_in -> sync_q1 -> sync_q2 (two flops). btn_s = sync_q2. No other logic touches btn_in.
- State encoding: LOW=2'b00, RISE_CHK=2'b01, HIGH=2'b10, FALL_CHK=2'b11.
- Transitions, evaluated each edge with rst=1:
  - LOW: btn_s=1 -> RISE_CHK, cnt<=0. Otherwise stay.
  - RISE_CHK: btn_s=0 -> LOW, cnt<=0 (bounce rejected). btn_s=1 and cnt==CNT_MAX-1 -> HIGH, pulse_out<=1. Otherwise cnt<=cnt+1.
  - HIGH: btn_s=0 -> FALL_CHK, cnt<=0. Otherwise stay.
  - FALL_CHK: btn_s=1 -> HIGH, cnt<=0. btn_s=0 and cnt==CNT_MAX-1 -> LOW. Otherwise cnt<=cnt+1.
  - Unreachable/illegal state (SEU, X-propagation): -> LOW next edge, cnt<=0.
- pulse_out:
  - Set only on the RISE_CHK->HIGH transition; cleared on every other edge, giving exactly one cycle high per accepted press.
  - Release (FALL_CHK->LOW) never generates a pulse.
- level_out: registered; 1 whenever next state is HIGH or FALL_CHK, else 0. It therefore rises in the same cycle as pulse_out.
- Latency: btn_in steadily high before edge E1 gives:
  - sync_q2=1 after E2;
  - RISE_CHK after E3;
  - pulse_out=1 in the cycle after edge E(3+CNT_MAX), i.e. 7 edges for CNT_MAX=4.
  - Release is symmetrical for level_out falling.
- Minimum accepted press width: CNT_MAX+1 consecutive synchronised high samples. Shorter glitches produce no pulse and no level change.
- Counter: unsigned CNT_W bits. It never exceeds CNT_MAX-1, so there is no wrap-around. The comparison is equality only.
- Button held indefinitely: stays in HIGH, single pulse only, no auto-repeat.
- Reset mid-debounce or mid-pulse: pulse_out is forced to 0 at that edge and the press is discarded.
- Button held through reset release: after rst returns to 1, the normal debounce runs from LOW and one pulse is generated, with the same latency as a fresh press measured from the release edge.
- Downstream contract: pulse_out is a clean registered level, safe to drive the toggle FSM din directly with no extra gating.

Decomposition:
- Shared package/header debounce_pkg:
  - state localparams LOW/RISE_CHK/HIGH/FALL_CHK;
  - state width 2;
  - default CNT_MAX.
- One natural sub-module: sync_2ff (1-bit two-flop synchroniser, synchronous active-low rst clears both flops), instantiated once.
- FSM, counter and output registers stay in debounce_pulse_gen as a sequential state/counter block plus a combinational next-state block.

Test Plan:
- Clean press: rst=0 for 3 edges, then btn_in=1 steady. Require pulse_out=1 for exactly one cycle, after edge 7 (CNT_MAX=4), level_out=1 from the same cycle, and p_state sequence 00->01->10.
- Bounce rejection: btn_in pattern 1,0,1,1,0 (one sample per edge), then 0. Require pulse_out never 1, level_out stays 0, and p_state returns to 00.
- Bouncy press then stable: 1,0,1 followed by 10 cycles of 1. Require exactly one pulse_out cycle, 4 edges after the last entry into RISE_CHK.
- Hold and release with a release bounce: hold 20 cycles, then 0,1,0 and steady 0. Require a single pulse, no pulse on release, and level_out falling 4 edges after the final FALL_CHK entry.
- Reset mid-debounce: assert rst=0 while p_state=01, cnt=2. Require all outputs 0 on the next edge. With btn_in still 1 after release, require one pulse 7 edges after rst deasserts.
- Back-to-back presses into the downstream toggle FSM: three validated presses separated by 10 low cycles. Require 3 pulses total and the downstream dout toggling 0->1->0->1.
